alu4_sequencer: RTL

Multi-cycle initiator for the 4-bit `alu4` datapath. It accepts a wide operation over a valid/ready request channel and executes it as NIBBLES back-to-back nibble operations on an external `alu4`, least-significant nibble first. Between nibbles it chains `carry_out` into `carry_in`, collects the result nibbles, and returns the wide result and flags over a valid/ready response channel. It sits between a control-plane requester and the combinational `alu4` instance.

---
 rtl/alu4_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu4_sequencer.sv
// Runs a wide ALU operation as NIBBLES back-to-back nibble ops on an external
// combinational alu4, LSB nibble first, chaining carry and returning the result.
module alu4_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [2:0]           req_select,
  input  logic                 req_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_select,
  output logic                 alu_carry_in,
  input  logic [3:0]           alu_out,
  input  logic                 alu_carry_out
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q,    idx_d;
  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic [W-1:0]    result_q, result_d;
  logic [2:0]      sel_q,    sel_d;
  logic            carry_q,  carry_d;

  logic            is_logic;
  logic [IW+1:0]   bit_ofs;

  assign is_logic = sel_q[2];
  assign bit_ofs  = {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state: accept in IDLE, one nibble per RUN cycle, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d      = req_a;
          b_d      = req_b;
          sel_d    = req_select;
          carry_d  = req_select[2] ? 1'b0 : req_carry;
          result_d = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[bit_ofs +: 4] = alu_out;
        if (!is_logic) carry_d = alu_carry_out;
        if (idx_q == IW'(NIBBLES - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; zero outside their active state.
  always_comb begin
    req_ready    = rst_n && (state_q == IDLE);
    rsp_valid    = 1'b0;
    rsp_result   = '0;
    rsp_carry    = 1'b0;
    rsp_zero     = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_select   = '0;
    alu_carry_in = 1'b0;
    if (state_q == RUN) begin
      alu_a        = a_q[bit_ofs +: 4];
      alu_b        = b_q[bit_ofs +: 4];
      alu_select   = sel_q;
      alu_carry_in = carry_q && !is_logic;
    end
    if (state_q == DONE) begin
      rsp_valid  = 1'b1;
      rsp_result = result_q;
      rsp_carry  = carry_q && !is_logic;
      rsp_zero   = ~|result_q;
    end
  end

endmodule
